// File: rtl/cls_spi_responder.sv
// cls_spi_responder: SPI mode-0 slave receiver modelling the PmodCLS end of the
// display link. It deserialises MOSI, buffers bytes in a first-word fall-through
// FIFO and reports per-frame byte counts and partial-byte errors.
// Optional feature macro: CLS_ESC_DETECT_EN builds the ESC [ j clear-command
// matcher that drives clear_seen. Without it, clear_seen is tied to 0.
module cls_spi_responder #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        sclk,
  input  logic                        mosi,
  input  logic                        ss,
  input  logic                        rd_en,
  input  logic                        ovf_clr,
  output logic [7:0]                  rd_data,
  output logic                        empty,
  output logic                        full,
  output logic [$clog2(FIFO_DEPTH):0] level,
  output logic                        frame_done,
  output logic [5:0]                  frame_bytes,
  output logic                        frame_err,
  output logic                        overflow,
  output logic                        clear_seen
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   LVL_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_END   = 2'd2;

  logic [SYNC_STAGES-1:0] sclk_sync, mosi_sync, ss_sync;
  logic                   sclk_q, ss_q;
  logic                   sclk_rise, ss_fall, ss_rise, mosi_bit;

  logic [1:0]    state;
  logic [7:0]    shreg;
  logic [2:0]    bit_cnt;
  logic [5:0]    byte_cnt;
  logic          push_q;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic          pop, wr;

  // Synchronise the pins and keep one extra copy for edge detection. ss resets
  // low so a select still asserted across reset release never looks like a fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sclk_sync <= '0;
      mosi_sync <= '0;
      ss_sync   <= '0;
      sclk_q    <= 1'b0;
      ss_q      <= 1'b0;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], mosi};
      ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss};
      sclk_q    <= sclk_sync[SYNC_STAGES-1];
      ss_q      <= ss_sync[SYNC_STAGES-1];
    end
  end

  assign sclk_rise = sclk_sync[SYNC_STAGES-1] & ~sclk_q;
  assign ss_fall   = ~ss_sync[SYNC_STAGES-1] & ss_q;
  assign ss_rise   = ss_sync[SYNC_STAGES-1] & ~ss_q;
  assign mosi_bit  = mosi_sync[SYNC_STAGES-1];

  // Frame FSM: shift bits on sclk rises, flag a completed byte for push one
  // cycle later, and report the frame summary from the one-cycle END state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= ST_IDLE;
      shreg       <= 8'h00;
      bit_cnt     <= 3'd0;
      byte_cnt    <= 6'd0;
      push_q      <= 1'b0;
      frame_done  <= 1'b0;
      frame_bytes <= 6'd0;
      frame_err   <= 1'b0;
    end else begin
      push_q     <= 1'b0;
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: if (ss_fall) begin
          state    <= ST_SHIFT;
          bit_cnt  <= 3'd0;
          byte_cnt <= 6'd0;
        end
        ST_SHIFT: if (ss_rise) begin
          state <= ST_END;
        end else if (sclk_rise) begin
          shreg   <= {shreg[6:0], mosi_bit};
          bit_cnt <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            push_q <= 1'b1;
            if (byte_cnt != 6'd63) byte_cnt <= byte_cnt + 6'd1;
          end
        end
        ST_END: begin
          frame_done  <= 1'b1;
          frame_bytes <= byte_cnt;
          frame_err   <= (bit_cnt != 3'd0);
          state       <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // A pop on an empty FIFO is ignored; a push into a full FIFO only lands if a
  // pop frees the slot in the same cycle.
  assign pop = rd_en & ~empty;
  assign wr  = push_q & (~full | pop);

  // FIFO storage; no reset needed since empty masks the read port.
  always_ff @(posedge clk) begin
    if (wr) mem[wptr] <= shreg;
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr     <= '0;
      rptr     <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr)  wptr <= wptr + PTR_ONE;
      if (pop) rptr <= rptr + PTR_ONE;
      case ({wr, pop})
        2'b10:   level <= level + LVL_ONE;
        2'b01:   level <= level - LVL_ONE;
        default: level <= level;
      endcase
      if (push_q & full & ~pop) overflow <= 1'b1;
      else if (ovf_clr)         overflow <= 1'b0;
    end
  end

  assign empty   = (level == '0);
  assign full    = (level == LVL_FULL);
  assign rd_data = empty ? 8'h00 : mem[rptr];

`ifdef CLS_ESC_DETECT_EN
  logic [1:0] esc_st;

  // ESC [ j matcher over every completed byte, dropped ones included.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      esc_st     <= 2'd0;
      clear_seen <= 1'b0;
    end else begin
      clear_seen <= 1'b0;
      if (state == ST_IDLE && ss_fall) begin
        esc_st <= 2'd0;
      end else if (push_q) begin
        if (esc_st == 2'd2 && shreg == 8'h6A) begin
          clear_seen <= 1'b1;
          esc_st     <= 2'd0;
        end else if (shreg == 8'h1B) begin
          esc_st <= 2'd1;
        end else if (esc_st == 2'd1 && shreg == 8'h5B) begin
          esc_st <= 2'd2;
        end else begin
          esc_st <= 2'd0;
        end
      end
    end
  end
`else
  assign clear_seen = 1'b0;
`endif

endmodule

// File: tb/tb_cls_spi_responder.sv
// Bench for cls_spi_responder: directed SPI frames with a scoreboard. Expected
// frame summaries and FIFO bytes are queued as stimulus is issued; monitors
// compare on frame_done pulses and on every accepted pop.
module tb_cls_spi_responder;

  localparam int SYNC = 2;
  localparam int HALF = 4;  // sclk = clk/8

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       sclk = 1'b0, mosi = 1'b0, ss = 1'b1;
  logic       rd_en = 1'b0, ovf_clr = 1'b0;
  logic [7:0] rd_data;
  logic       empty, full, frame_done, frame_err, overflow, clear_seen;
  logic [3:0] level;
  logic [5:0] frame_bytes;

  int checks = 0;
  int errors = 0;
  int clr_cnt = 0;

  logic [6:0] exp_frames[$];  // {err, bytes}
  logic [7:0] exp_data[$];
  logic [7:0] fbytes[16];

  cls_spi_responder #(.FIFO_DEPTH(8), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst(rst), .sclk(sclk), .mosi(mosi), .ss(ss),
    .rd_en(rd_en), .ovf_clr(ovf_clr), .rd_data(rd_data), .empty(empty),
    .full(full), .level(level), .frame_done(frame_done),
    .frame_bytes(frame_bytes), .frame_err(frame_err), .overflow(overflow),
    .clear_seen(clear_seen)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Frame monitor
  always @(negedge clk) begin
    if (frame_done) begin
      if (exp_frames.size() == 0) check("unexpected_frame_done", 32'd1, 32'd0);
      else begin
        logic [6:0] e;
        e = exp_frames.pop_front();
        check("frame_bytes", {26'd0, frame_bytes}, {26'd0, e[5:0]});
        check("frame_err", {31'd0, frame_err}, {31'd0, e[6]});
      end
    end
  end

  // Data monitor
  always @(negedge clk) begin
    if (rd_en && !empty) begin
      if (exp_data.size() == 0) check("unexpected_data", {24'd0, rd_data}, 32'hFFFF_FFFF);
      else check("rd_data", {24'd0, rd_data}, {24'd0, exp_data.pop_front()});
    end
    if (clear_seen) clr_cnt++;
  end

  // One bit, MSB-first caller; optionally pulse rd_en on the push cycle.
  task automatic send_bit(input logic b, input bit pop_on_push);
    mosi = b;
    tick(HALF);
    sclk = 1'b1;
    if (pop_on_push) begin
      tick(SYNC + 1);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
    end else tick(HALF);
    sclk = 1'b0;
  endtask

  task automatic send_frame(input int nbytes, input int xbits, input logic [7:0] xval,
                            input bit pop_last);
    ss = 1'b0;
    tick(6);
    for (int i = 0; i < nbytes; i++)
      for (int k = 7; k >= 0; k--)
        send_bit(fbytes[i][k], pop_last && (i == nbytes - 1) && (k == 0));
    for (int k = 7; k > 7 - xbits; k--) send_bit(xval[k], 1'b0);
    tick(6);
    ss = 1'b1;
    tick(12);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    tick(1);
  endtask

  initial begin
    // Reset and idle
    tick(3);
    check("reset_outputs",
          {8'd0, rd_data, empty, full, level, frame_done, frame_bytes, frame_err, overflow, clear_seen},
          {8'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick(1);
      check("idle_outputs",
            {8'd0, rd_data, empty, full, level, frame_done, frame_bytes, frame_err, overflow, clear_seen},
            {8'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0});
    end

    // Single byte
    fbytes[0] = 8'hA5;
    exp_frames.push_back({1'b0, 6'd1});
    exp_data.push_back(8'hA5);
    send_frame(1, 0, 8'h00, 1'b0);
    check("single_level", {28'd0, level}, 32'd1);
    check("single_head", {24'd0, rd_data}, 32'hA5);
    pop_one();
    check("single_empty", {31'd0, empty}, 32'd1);

    // Partial trailing byte is discarded
    fbytes[0] = 8'h3C;
    exp_frames.push_back({1'b1, 6'd1});
    exp_data.push_back(8'h3C);
    send_frame(1, 5, 8'b10101000, 1'b0);
    check("partial_level", {28'd0, level}, 32'd1);
    check("partial_head", {24'd0, rd_data}, 32'h3C);
    pop_one();

    // Overflow: 10 bytes into an 8-deep FIFO
    for (int i = 0; i < 10; i++) fbytes[i] = 8'(i);
    exp_frames.push_back({1'b0, 6'd10});
    for (int i = 0; i < 8; i++) exp_data.push_back(8'(i));
    send_frame(10, 0, 8'h00, 1'b0);
    check("ovf_full", {31'd0, full}, 32'd1);
    check("ovf_level", {28'd0, level}, 32'd8);
    check("ovf_flag", {31'd0, overflow}, 32'd1);
    ovf_clr = 1'b1;
    tick(1);
    ovf_clr = 1'b0;
    check("ovf_clear", {31'd0, overflow}, 32'd0);

    // Full FIFO: push coincides with a pop
    fbytes[0] = 8'h55;
    exp_frames.push_back({1'b0, 6'd1});
    exp_data.push_back(8'h55);
    send_frame(1, 0, 8'h00, 1'b1);
    check("fullpp_level", {28'd0, level}, 32'd8);
    check("fullpp_ovf", {31'd0, overflow}, 32'd0);
    for (int i = 0; i < 8; i++) pop_one();
    check("drain_empty", {31'd0, empty}, 32'd1);

    // Clear command detection
    fbytes[0] = 8'h1B; fbytes[1] = 8'h5B; fbytes[2] = 8'h6A;
    exp_frames.push_back({1'b0, 6'd3});
    exp_data.push_back(8'h1B); exp_data.push_back(8'h5B); exp_data.push_back(8'h6A);
    send_frame(3, 0, 8'h00, 1'b0);
`ifdef CLS_ESC_DETECT_EN
    check("clear_one", clr_cnt, 32'd1);
`else
    check("clear_off", clr_cnt, 32'd0);
`endif
    fbytes[0] = 8'h1B; fbytes[1] = 8'h1B; fbytes[2] = 8'h5B; fbytes[3] = 8'h6A;
    exp_frames.push_back({1'b0, 6'd4});
    for (int i = 0; i < 4; i++) exp_data.push_back(fbytes[i]);
    send_frame(4, 0, 8'h00, 1'b0);
`ifdef CLS_ESC_DETECT_EN
    check("clear_two", clr_cnt, 32'd2);
`else
    check("clear_off2", clr_cnt, 32'd0);
`endif
    check("clear_level", {28'd0, level}, 32'd7);
    for (int i = 0; i < 7; i++) pop_one();

    // Reset mid-frame, ss held low across release: no frame may start
    ss = 1'b0;
    tick(6);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 1'b0);
    rst = 1'b0;
    tick(3);
    check("midrst_outputs",
          {8'd0, rd_data, empty, full, level, frame_done, frame_bytes, frame_err, overflow, clear_seen},
          {8'd0, 8'h00, 1'b1, 1'b0, 4'd0, 1'b0, 6'd0, 1'b0, 1'b0, 1'b0});
    rst = 1'b1;
    tick(4);
    for (int k = 0; k < 8; k++) send_bit(1'b1, 1'b0);
    tick(6);
    ss = 1'b1;
    tick(12);
    check("midrst_no_push", {28'd0, level}, 32'd0);

    // A normal frame works again afterwards
    fbytes[0] = 8'hC3;
    exp_frames.push_back({1'b0, 6'd1});
    exp_data.push_back(8'hC3);
    send_frame(1, 0, 8'h00, 1'b0);
    pop_one();

    tick(5);
    check("frames_outstanding", exp_frames.size(), 32'd0);
    check("data_outstanding", exp_data.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/cls_spi_responder.md
# cls_spi_responder

SPI slave receiver that models the PmodCLS end of the display link. It is driven by the SPI master interface's serial output: SCLK, MOSI and active-low SS. It deserialises MOSI bytes, buffers them in a small FIFO and reports per-frame byte counts and errors. Benches and on-chip loopback checks use it to confirm exactly what the master sent. Nothing is driven back on MISO.

## Interface
Parameters:
- FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, at least 2.
- SYNC_STAGES, 2, flip-flop stages on each of sclk, mosi and ss; at least 2.

Ports:
- clk  in  1  system clock; all logic is in this domain.
- rst  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from the master. Asynchronous to clk. Idles low (mode 0).
- mosi  in  1  serial data from the master, sent MSB first.
- ss  in  1  slave select, active-low, asynchronous.
- rd_en  in  1  pops the FIFO head. Ignored when the FIFO is empty.
- ovf_clr  in  1  clears the sticky overflow flag.
- rd_data  out  8  FIFO head (first-word fall-through). Holds 8'h00 when empty.
- empty  out  1  FIFO empty.
- full  out  1  FIFO full.
- level  out  $clog2(FIFO_DEPTH)+1  number of bytes in the FIFO.
- frame_done  out  1  one-cycle pulse after ss deasserts.
- frame_bytes  out  6  count of complete bytes in the last frame. Saturates at 63. Updates with frame_done.
- frame_err  out  1  valid with frame_done. Set when the frame ended on a partial byte.
- overflow  out  1  sticky; set when a byte is dropped because the FIFO is full.
- clear_seen  out  1  one-cycle pulse. Present only with CLS_ESC_DETECT_EN.

## Operation
- Inputs are synchronised through SYNC_STAGES flops. Edges are detected by comparing the last synchroniser stage with one extra registered copy.
- States:
  - IDLE: ss high. Goes to SHIFT on a detected ss fall; bit_cnt and byte_cnt are cleared to 0.
  - SHIFT: on each detected sclk rise, the synchronised mosi bit is shifted into shreg LSB and bit_cnt (3 bits) increments.
    - When bit_cnt wraps from 7 to 0, the completed byte is pushed and byte_cnt increments (saturating at 63).
    - A detected ss rise goes to END.
  - END: lasts one cycle.
    - frame_done=1, frame_bytes=byte_cnt, frame_err=(bit_cnt!=0).
    - The partial byte is discarded, never pushed.
    - Returns to IDLE.
- sclk edges seen while in IDLE are ignored.
- FIFO behaviour:
  - Push while full with no rd_en: byte dropped, overflow set.
  - Push and rd_en in the same cycle while full: both succeed, level unchanged.
  - Push and rd_en in the same cycle while empty: the push succeeds, the pop is ignored, level becomes 1.
  - rd_en while empty: no effect.
  - Pointers wrap modulo FIFO_DEPTH.
- overflow: if ovf_clr and a new overflow event occur in the same cycle, overflow stays 1.
- Reset asserted mid-frame:
  - All outputs go to 0 except empty, which goes to 1. rd_data=8'h00.
  - FIFO is flushed and the FSM returns to IDLE.
  - After release, if ss is still low, no frame starts until ss has been seen high and then falls again.

## Timing
- Reset values: rd_data=8'h00, empty=1, full=0, level=0, frame_done=0, frame_bytes=0, frame_err=0, overflow=0, clear_seen=0.
- Input constraints: sclk high and low phases each at least SYNC_STAGES+2 clk cycles. ss fall to first sclk rise and last sclk fall to ss rise each at least SYNC_STAGES+2 cycles.
- Latency from the 8th sclk rise at the pin to empty falling / rd_data valid: SYNC_STAGES+2 clk cycles.
- Latency from ss rise at the pin to the frame_done pulse: SYNC_STAGES+2 clk cycles.
- rd_en pop: rd_data shows the next entry on the following cycle.

## Configuration
- CLS_ESC_DETECT_EN defined:
  - A 3-byte matcher watches every received byte, including bytes dropped on overflow.
  - The sequence 8'h1B, 8'h5B, 8'h6A (ESC [ j, the PmodCLS clear command) pulses clear_seen one cycle after the 8'h6A is pushed.
  - A mismatch restarts matching; a mismatching 8'h1B is taken as the first byte of a new match.
  - Matching resets at each ss fall.
- CLS_ESC_DETECT_EN undefined: the matcher is not built and clear_seen is tied to 0.

## Test plan
- Reset then idle: rst low for 3 cycles, then high with ss=1 → empty=1, level=0, and all other outputs 0 for 100 cycles.
- Single byte: frame 8'hA5 with sclk at clk/8 → after ss rise, rd_data=8'hA5, level=1, frame_done pulse with frame_bytes=1 and frame_err=0. After rd_en, empty=1.
- Partial byte: 8'h3C, then 5 more bits, then ss rise → frame_bytes=1, frame_err=1, level=1, rd_data=8'h3C.
- Overflow: 10 bytes 8'h00..8'h09 with no reads → full=1, level=8, overflow=1.
  - Reads return 8'h00..8'h07 in order.
  - ovf_clr clears overflow.
- Full-cycle push and pop: with FIFO full, a push coincides with rd_en → level stays 8, overflow=0.
- Clear command (macro defined): frame 8'h1B, 8'h5B, 8'h6A → exactly one clear_seen pulse.
  - Frame 8'h1B, 8'h1B, 8'h5B, 8'h6A → one pulse.
  - Macro undefined → clear_seen stays 0.
